// File: rtl/pc_ir_unit.sv
// Fetch-side register slice: PC, IR and memory data register plus instruction field decode.
// Optional INST_COUNT_EN macro adds a 32-bit retired-fetch counter on inst_count.
module pc_ir_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] SYSCALL_ADDR = 32'h0000_0040
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [21:0] ctrl_in,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] alu_out,
  input  logic [31:0] x_reg,
  input  logic [31:0] z_reg,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [5:0]  op_out,
  output logic [5:0]  funct_out,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  sh,
  output logic [31:0] imm_sext,
  output logic [31:0] jta,
  output logic [31:0] data_reg,
  output logic        pc_misalign,
  output logic [31:0] inst_count
);

  localparam int unsigned XLEN = 32;

  logic       jumpAddr;
  logic [1:0] pcSrc;
  logic       pcWrite;
  logic       instData;
  logic       memRead;
  logic       memWrite;
  logic       irWrite;
  logic       unusedCtrl;

  assign jumpAddr   = ctrl_in[21];
  assign pcSrc      = ctrl_in[20:19];
  assign pcWrite    = ctrl_in[18];
  assign instData   = ctrl_in[17];
  assign memRead    = ctrl_in[16];
  assign memWrite   = ctrl_in[15];
  assign irWrite    = ctrl_in[14];
  assign unusedCtrl = ^ctrl_in[13:0];

  assign mem_rd   = memRead;
  assign mem_wr   = memWrite;
  assign mem_addr = instData ? z_reg : pc;

  // Instruction field decode, zero latency from the IR
  assign op_out    = ir[31:26];
  assign funct_out = ir[5:0];
  assign rs        = ir[25:21];
  assign rt        = ir[20:16];
  assign rd        = ir[15:11];
  assign sh        = ir[10:6];
  assign imm_sext  = {{16{ir[15]}}, ir[15:0]};
  assign jta       = {pc[31:28], ir[25:0], 2'b00};

  logic [XLEN-1:0] pcTarget;

  always_comb begin
    pcTarget = jta;
    unique case (pcSrc)
      2'b00:   pcTarget = jumpAddr ? SYSCALL_ADDR : jta;
      2'b01:   pcTarget = x_reg;
      2'b10:   pcTarget = z_reg;
      default: pcTarget = alu_out;
    endcase
  end

  // PC is always stored word-aligned; a misaligned target sets the sticky flag
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      ir          <= '0;
      data_reg    <= '0;
      pc_misalign <= 1'b0;
    end else begin
      if (pcWrite) begin
        pc <= {pcTarget[XLEN-1:2], 2'b00};
        if (pcTarget[1:0] != 2'b00) pc_misalign <= 1'b1;
      end
      if (irWrite) ir <= mem_rdata;
      if (memRead && instData) data_reg <= mem_rdata;
    end
  end

`ifdef INST_COUNT_EN
  logic [XLEN-1:0] instCount;

  always_ff @(posedge clk) begin
    if (reset) instCount <= '0;
    else if (irWrite) instCount <= instCount + XLEN'(1);
  end

  assign inst_count = instCount;
`else
  assign inst_count = 32'h0;
`endif

endmodule

// File: doc/pc_ir_unit.md
# pc_ir_unit

- Fetch-side register slice that holds the program counter (PC), instruction register (IR) and memory data register (DR) for the multicycle core.
- Decodes the 22-bit control word produced by the controller FSM: PCWrite, PCSrc, JumpAddr, Inst'Data, MemRead and IRWrite.
- Feeds op/funct back to the FSM and supplies the instruction fields and memory address to the datapath.
- Sits between instruction/data memory and the controller, alongside the ALU/register-file datapath.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- SYSCALL_ADDR, 32'h0000_0040, PC target when JumpAddr=1 and PCSrc=00.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ctrl_in  in  22  control word. Bit map: [21] JumpAddr, [20:19] PCSrc, [18] PCWrite, [17] InstData, [16] MemRead, [15] MemWrite, [14] IRWrite, others ignored.
- mem_rdata  in  32  memory read data, valid in the same cycle as mem_addr.
- alu_out  in  32  combinational ALU result.
- x_reg  in  32  datapath x register.
- z_reg  in  32  datapath z (ALUout) register.
- mem_addr  out  32  InstData=0 → pc; InstData=1 → z_reg.
- mem_rd  out  1  ctrl_in[16] passthrough.
- mem_wr  out  1  ctrl_in[15] passthrough.
- pc  out  32  current PC register.
- ir  out  32  instruction register.
- op_out  out  6  ir[31:26], to the FSM op_in.
- funct_out  out  6  ir[5:0], to the FSM funct_in.
- rs, rt, rd  out  5 each  ir[25:21], ir[20:16], ir[15:11].
- sh  out  5  ir[10:6].
- imm_sext  out  32  sign-extended ir[15:0].
- jta  out  32  {pc[31:28], ir[25:0], 2'b00}.
- data_reg  out  32  memory data register.
- pc_misalign  out  1  sticky flag.
- inst_count  out  32  see Configuration.

## Operation

PC update:
- When PCWrite=1, pc ← target with bits [1:0] forced to 00.
- Target by PCSrc:
  - 00 → SYSCALL_ADDR if JumpAddr=1, else jta (computed from the current pc and ir).
  - 01 → x_reg.
  - 10 → z_reg.
  - 11 → alu_out.
- If the selected target has [1:0]≠00 when written, pc_misalign ← 1. The flag stays set until reset.

IR and DR:
- IRWrite=1: ir ← mem_rdata, sampled at mem_addr of the same cycle.
- MemRead=1 and InstData=1: data_reg ← mem_rdata. Otherwise data_reg holds.

Simultaneous events:
- PCWrite and IRWrite in the same cycle (fetch): ir captures the word at the old pc, and pc takes the new value. Both use pre-edge values.
- IRWrite=1 with InstData=1 is illegal. ir still loads mem_rdata (the data word), and no error is flagged.
- MemWrite has no effect inside this block beyond the mem_wr passthrough.

Combinational outputs:
- All decode fields (op_out, funct_out, rs, rt, rd, sh, imm_sext, jta) and mem_addr are purely combinational from registers or inputs, with zero latency.

## Timing

- Reset (synchronous, on a rising edge with reset=1):
  - pc=RESET_PC, ir=0, data_reg=0, pc_misalign=0, inst_count=0.
  - op_out=funct_out=0, i.e. a valid R-type, so the FSM can leave S0.
- reset has priority over every ctrl_in write in the same cycle. Reset asserted mid-instruction discards all pending updates.
- Latency:
  - pc, ir and data_reg are visible one cycle after the write enable.
  - mem_addr switches in the same cycle as InstData.
- A J/JAL in decode (PCWrite, PCSrc=00) uses the ir loaded during the preceding fetch.
- Wrap-around: alu_out=32'hFFFF_FFFC+4 → pc=0, no flag.

## Configuration

- INST_COUNT_EN defined: inst_count is a 32-bit counter.
  - Increments on every non-reset cycle with IRWrite=1.
  - Wraps FFFF_FFFF→0.
  - Cleared by reset.
- INST_COUNT_EN not defined: no counter register; inst_count is tied to 32'h0.

## Test plan

- Reset with RESET_PC=32'h100 → pc=32'h100, ir=0, op_out=0, pc_misalign=0, inst_count=0.
- Fetch cycle: mem_rdata=32'h0800_0010, ctrl PCWrite=1, PCSrc=11, IRWrite=1, MemRead=1, alu_out=32'h104 → next cycle ir=32'h0800_0010, op_out=6'b000010, pc=32'h104, mem_addr was 32'h100.
- Jump: pc=32'h1000_0104, ir=32'h0800_0010, PCWrite=1, PCSrc=00, JumpAddr=0 → pc=32'h1000_0040. Same with JumpAddr=1 → pc=SYSCALL_ADDR.
- LW data path: z_reg=32'h200, InstData=1, MemRead=1, mem_rdata=32'hDEAD_BEEF → mem_addr=32'h200 that cycle, data_reg=32'hDEAD_BEEF next cycle, ir unchanged.
- JR misaligned: x_reg=32'h0000_0103, PCWrite=1, PCSrc=01 → pc=32'h100, pc_misalign=1, and the flag stays 1 after a later aligned write.
- Reset mid-op: reset=1 together with IRWrite=1, PCWrite=1 → pc=RESET_PC, ir=0. With INST_COUNT_EN, 5 fetches then reset → inst_count 5 then 0.
